// File: rtl/multiclock_mdu_if.sv
// Start/operand/result bundle between the execute stage and the multi-cycle MDU.
// The execute stage drives the master side; the MDU implements the slave side.
interface multiclock_mdu_if #(
    parameter int XLEN = 32
);
    logic            is_multiclock_input;
    logic [5:0]      alucode;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] result;
    logic            done;
    logic            busy;

    modport master (
        output is_multiclock_input, alucode, op1, op2,
        input  result, done, busy
    );

    modport slave (
        input  is_multiclock_input, alucode, op1, op2,
        output result, done, busy
    );
endinterface

// File: rtl/multiclock_mdu.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: pipelined multiplier of
// MUL_STAGES depth, radix-2 restoring divider, one-cycle path for special divides.
module multiclock_mdu #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    multiclock_mdu_if.slave mdu
);
    localparam logic [5:0] ALU_MUL    = 6'd32;
    localparam logic [5:0] ALU_MULH   = 6'd33;
    localparam logic [5:0] ALU_MULHSU = 6'd34;
    localparam logic [5:0] ALU_MULHU  = 6'd35;
    localparam logic [5:0] ALU_DIV    = 6'd36;
    localparam logic [5:0] ALU_DIVU   = 6'd37;
    localparam logic [5:0] ALU_REM    = 6'd38;
    localparam logic [5:0] ALU_REMU   = 6'd39;
    localparam int         CNT_W      = $clog2(XLEN + MUL_STAGES + 2);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [5:0]        r_code;
    logic              r_busy;
    logic              r_done;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_result;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_fix;
    logic [2*XLEN-1:0] r_pipe [MUL_STAGES];

    logic              w_is_mul;
    logic              w_is_div;
    logic              w_div_signed;
    logic              w_is_quot;
    logic              w_accept;
    logic              w_special;
    logic              w_finish;
    logic              w_sa;
    logic              w_sb;
    logic              w_ge;
    logic [2*XLEN-1:0] w_ma;
    logic [2*XLEN-1:0] w_mb;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic [XLEN-1:0]   w_fix;
    logic [XLEN-1:0]   w_final;
    logic [XLEN-1:0]   w_diff;
    logic [XLEN:0]     w_shift;

    always_comb begin
        w_is_mul     = (mdu.alucode == ALU_MUL)  || (mdu.alucode == ALU_MULH) ||
                       (mdu.alucode == ALU_MULHSU) || (mdu.alucode == ALU_MULHU);
        w_is_div     = (mdu.alucode == ALU_DIV)  || (mdu.alucode == ALU_DIVU) ||
                       (mdu.alucode == ALU_REM)  || (mdu.alucode == ALU_REMU);
        w_div_signed = (mdu.alucode == ALU_DIV)  || (mdu.alucode == ALU_REM);
        w_is_quot    = (mdu.alucode == ALU_DIV)  || (mdu.alucode == ALU_DIVU);
        w_accept     = mdu.is_multiclock_input && !r_busy && (w_is_mul || w_is_div);

        // Sign-extending to 2*XLEN makes a plain modular multiply yield the exact signed product.
        w_sa   = (mdu.alucode != ALU_MULHU);
        w_sb   = (mdu.alucode == ALU_MULH) || (mdu.alucode == ALU_MUL);
        w_ma   = {{XLEN{w_sa & mdu.op1[XLEN-1]}}, mdu.op1};
        w_mb   = {{XLEN{w_sb & mdu.op2[XLEN-1]}}, mdu.op2};
        w_prod = w_ma * w_mb;

        w_abs1 = (w_div_signed && mdu.op1[XLEN-1]) ? -mdu.op1 : mdu.op1;
        w_abs2 = (w_div_signed && mdu.op2[XLEN-1]) ? -mdu.op2 : mdu.op2;

        w_special = (mdu.op2 == '0) ||
                    (w_div_signed && (mdu.op1 == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.op2 == '1));
        if (mdu.op2 == '0) begin
            w_fix = w_is_quot ? '1 : mdu.op1;
        end else begin
            w_fix = w_is_quot ? mdu.op1 : '0;
        end

        w_shift = {r_rem, r_quo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_dvs});
        w_diff  = w_shift[XLEN-1:0] - r_dvs;
    end

    always_comb begin
        w_final = r_result;
        case (r_state)
            S_MUL: w_final = (r_code == ALU_MUL) ? r_pipe[MUL_STAGES-1][XLEN-1:0]
                                                 : r_pipe[MUL_STAGES-1][2*XLEN-1:XLEN];
            S_DIV: begin
                if ((r_code == ALU_DIV) || (r_code == ALU_DIVU)) begin
                    w_final = r_neg_q ? -r_quo : r_quo;
                end else begin
                    w_final = r_neg_r ? -r_rem : r_rem;
                end
            end
            S_FIX:   w_final = r_fix;
            default: w_final = r_result;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_is_mul ? S_MUL : (w_special ? S_FIX : S_DIV);
            S_MUL:  if (r_cnt == CNT_W'(MUL_STAGES - 1)) w_state_next = S_IDLE;
            S_DIV:  if (r_cnt == CNT_W'(XLEN)) w_state_next = S_IDLE;
            S_FIX:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        w_finish = (r_state != S_IDLE) && (w_state_next == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_code   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_fix    <= '0;
        end else begin
            r_done <= w_finish;
            // busy covers the done cycle too, so the next start lands one edge later.
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
            if (w_finish) begin
                r_result <= w_final;
            end
            if (w_accept) begin
                r_cnt   <= '0;
                r_code  <= mdu.alucode;
                r_quo   <= w_abs1;
                r_dvs   <= w_abs2;
                r_rem   <= '0;
                r_fix   <= w_fix;
                r_neg_q <= w_div_signed && (mdu.op1[XLEN-1] ^ mdu.op2[XLEN-1]);
                r_neg_r <= w_div_signed && mdu.op1[XLEN-1];
            end else if (r_state == S_MUL) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if ((r_state == S_DIV) && (r_cnt != CNT_W'(XLEN))) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_quo <= {r_quo[XLEN-2:0], w_ge};
                r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            if (w_accept && w_is_mul) begin
                r_pipe[0] <= w_prod;
            end
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign mdu.result = r_result;
    assign mdu.done   = r_done;
    assign mdu.busy   = r_busy;
endmodule

// File: tb/tb_multiclock_mdu.sv
// Directed bench for multiclock_mdu: 32-bit/4-stage and 64-bit/1-stage instances,
// checking results, latencies, busy/done framing, ignored starts and reset abort.
module tb_multiclock_mdu;
    localparam logic [5:0] ALU_MUL    = 6'd32;
    localparam logic [5:0] ALU_MULH   = 6'd33;
    localparam logic [5:0] ALU_MULHSU = 6'd34;
    localparam logic [5:0] ALU_MULHU  = 6'd35;
    localparam logic [5:0] ALU_DIV    = 6'd36;
    localparam logic [5:0] ALU_DIVU   = 6'd37;
    localparam logic [5:0] ALU_REM    = 6'd38;
    localparam logic [5:0] ALU_REMU   = 6'd39;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multiclock_mdu_if #(.XLEN(32)) bus32 ();
    multiclock_mdu_if #(.XLEN(64)) bus64 ();

    multiclock_mdu #(.XLEN(32), .MUL_STAGES(4)) dut32 (.clk(clk), .rst_n(rst_n), .mdu(bus32));
    multiclock_mdu #(.XLEN(64), .MUL_STAGES(1)) dut64 (.clk(clk), .rst_n(rst_n), .mdu(bus64));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op on the 32-bit unit; optionally fire a second start mid-operation.
    task automatic run32(input string tag, input logic [5:0] code, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                         input bit inject);
        int lat;
        int busy_drop;
        int extra_done;
        lat = -1;
        busy_drop = 0;
        extra_done = 0;
        @(negedge clk);
        bus32.is_multiclock_input = 1'b1;
        bus32.alucode = code;
        bus32.op1 = a;
        bus32.op2 = b;
        @(posedge clk); #1;
        bus32.is_multiclock_input = 1'b0;
        bus32.op1 = $urandom;
        bus32.op2 = $urandom;
        check_eq({tag, "_busy_e0"}, 64'(bus32.busy), 64'd1);
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (inject && k == 5) begin
                bus32.is_multiclock_input = 1'b1;
                bus32.alucode = ALU_DIVU;
                bus32.op1 = 32'd9;
                bus32.op2 = 32'd3;
            end
            if (inject && k == 6) bus32.is_multiclock_input = 1'b0;
            if (bus32.done) lat = k;
            else if (!bus32.busy) busy_drop++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_result"}, 64'(bus32.result), 64'(exp_res));
        check_eq({tag, "_busy_done"}, 64'(bus32.busy), 64'd1);
        check_eq({tag, "_busy_gap"}, 64'(busy_drop), 64'd0);
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, 64'(bus32.done), 64'd0);
        check_eq({tag, "_busy_end"}, 64'(bus32.busy), 64'd0);
        check_eq({tag, "_hold"}, 64'(bus32.result), 64'(exp_res));
        if (inject) begin
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (bus32.done) extra_done++;
            end
            check_eq({tag, "_extra_done"}, 64'(extra_done), 64'd0);
        end
        $display("op %s code=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d",
                 tag, code, a, b, bus32.result, lat);
    endtask

    task automatic run64(input string tag, input logic [5:0] code, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_res);
        int lat;
        lat = -1;
        @(negedge clk);
        bus64.is_multiclock_input = 1'b1;
        bus64.alucode = code;
        bus64.op1 = a;
        bus64.op2 = b;
        @(posedge clk); #1;
        bus64.is_multiclock_input = 1'b0;
        bus64.op1 = '0;
        bus64.op2 = '0;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (bus64.done) lat = k;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd1);
        check_eq({tag, "_result"}, bus64.result, exp_res);
        @(posedge clk); #1;
        check_eq({tag, "_busy_end"}, 64'(bus64.busy), 64'd0);
        $display("op %s code=%0d a=0x%016h b=0x%016h result=0x%016h latency=%0d",
                 tag, code, a, b, bus64.result, lat);
    endtask

    initial begin
        int n_done;
        int n_busy;
        bus32.is_multiclock_input = 1'b0;
        bus32.alucode = '0;
        bus32.op1 = '0;
        bus32.op2 = '0;
        bus64.is_multiclock_input = 1'b0;
        bus64.alucode = '0;
        bus64.op1 = '0;
        bus64.op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_result", 64'(bus32.result), 64'd0);
        check_eq("rst_done", 64'(bus32.done), 64'd0);
        check_eq("rst_busy", 64'(bus32.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run32("mul",    ALU_MUL,    32'h00003141, 32'h00005926, 4,  32'h1126e8a6, 1'b0);
        run32("mulh",   ALU_MULH,   32'd12345678, -32'sd9876543, 4, 32'hffff911a, 1'b0);
        run32("mulhsu", ALU_MULHSU, 32'hffffffff, 32'd1234578,  4,  32'hffffffff, 1'b0);
        run32("mulhu",  ALU_MULHU,  32'hffffffff, 32'hffffffff, 4,  32'hfffffffe, 1'b0);
        run32("div",    ALU_DIV,    -32'sd7,      32'd2,        33, 32'hfffffffd, 1'b0);
        run32("rem",    ALU_REM,    -32'sd7,      32'd2,        33, 32'hffffffff, 1'b0);
        run32("div_nd", ALU_DIV,    32'd7,        -32'sd2,      33, 32'hfffffffd, 1'b0);
        run32("rem_nd", ALU_REM,    32'd7,        -32'sd2,      33, 32'h00000001, 1'b0);
        run32("divu",   ALU_DIVU,   32'd100,      32'd7,        33, 32'd14,       1'b0);
        run32("remu",   ALU_REMU,   32'd100,      32'd7,        33, 32'd2,        1'b0);
        run32("divu_z", ALU_DIVU,   32'd1234,     32'd0,        1,  32'hffffffff, 1'b0);
        run32("rem_z",  ALU_REM,    32'd5,        32'd0,        1,  32'd5,        1'b0);
        run32("div_ov", ALU_DIV,    32'h80000000, 32'hffffffff, 1,  32'h80000000, 1'b0);
        run32("rem_ov", ALU_REM,    32'h80000000, 32'hffffffff, 1,  32'd0,        1'b0);
        run32("busy_ign", ALU_DIVU, 32'd100,      32'd7,        33, 32'd14,       1'b1);

        // A start with a non-M code must leave the unit untouched.
        n_done = 0;
        n_busy = 0;
        @(negedge clk);
        bus32.is_multiclock_input = 1'b1;
        bus32.alucode = 6'd0;
        bus32.op1 = 32'd3;
        bus32.op2 = 32'd4;
        @(posedge clk); #1;
        bus32.is_multiclock_input = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus32.done) n_done++;
            if (bus32.busy) n_busy++;
            @(posedge clk); #1;
        end
        check_eq("nonm_done", 64'(n_done), 64'd0);
        check_eq("nonm_busy", 64'(n_busy), 64'd0);
        check_eq("nonm_result", 64'(bus32.result), 64'd14);
        $display("op nonm code=0 ignored done_count=%0d busy_count=%0d", n_done, n_busy);

        // Reset asserted at E10 of a divide aborts it immediately.
        @(negedge clk);
        bus32.is_multiclock_input = 1'b1;
        bus32.alucode = ALU_DIVU;
        bus32.op1 = 32'd100;
        bus32.op2 = 32'd7;
        @(posedge clk); #1;
        bus32.is_multiclock_input = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 64'(bus32.busy), 64'd0);
        check_eq("abort_done", 64'(bus32.done), 64'd0);
        check_eq("abort_result", 64'(bus32.result), 64'd0);
        $display("op abort divu reset at E10 busy=%0d done=%0d result=0x%08h",
                 bus32.busy, bus32.done, bus32.result);
        @(negedge clk);
        rst_n = 1'b1;
        run32("mul_post", ALU_MUL, 32'h00003141, 32'h00005926, 4, 32'h1126e8a6, 1'b0);

        run64("mul64",   ALU_MUL,   64'h3141, 64'h5926, 64'h1126e8a6);
        run64("mulhu64", ALU_MULHU, 64'hffffffffffffffff, 64'hffffffffffffffff,
              64'hfffffffffffffffe);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
